// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared slow-clock constants and meter state type
package clock_pkg;

    // Defaults shared with the clock dividers so both ends agree
    localparam int CNT_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 200000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - synchronizer, optional deglitch (TICK_METER_DEGLITCH_EN), rise/fall pulses
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sq_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   lvl;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef TICK_METER_DEGLITCH_EN
    logic [1:0] hist_q;

    // A new level is accepted only once it has held for two further cycles
    assign lvl = ((sync_lvl == hist_q[0]) && (sync_lvl == hist_q[1])) ? sync_lvl : prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_lvl};
        end
    end
`else
    assign lvl = sync_lvl;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sq_i};
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clock_tick_meter.sv
// rtl/clock_tick_meter.sv - tick generation, period/high-time measurement, lock and loss tracking
module clock_tick_meter
    import clock_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sq_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rise;
    logic             fall;
    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_q, meas_d;
    logic             lost_q, lost_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_i (clk_in),
        .rst_ni(rst_n),
        .sq_i  (sq_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    always_comb begin
        state_d   = state_q;
        run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        meas_d    = 1'b0;
        lost_d    = lost_q;

        if (rise) begin
            run_cnt_d = CNT_ONE;
            lost_d    = 1'b0;
        end
        if (fall) begin
            hi_cap_d = run_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARMED;
                end
            end
            ARMED, LOCKED: begin
                // A tick landing on the timeout cycle still counts as a valid edge
                if (rise) begin
                    period_d = run_cnt_q;
                    high_d   = hi_cap_q;
                    meas_d   = 1'b1;
                    state_d  = LOCKED;
                end else if (run_cnt_q == TIMEOUT_C) begin
                    state_d = IDLE;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            meas_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            meas_q    <= meas_d;
            lost_q    <= lost_d;
        end
    end

    assign tick       = rise;
    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_q;
    assign locked     = (state_q == LOCKED);
    assign lost       = lost_q;

endmodule

// File: tb/tb_clock_tick_meter.sv
// tb/tb_clock_tick_meter.sv - scoreboard bench for clock_tick_meter
module tb_clock_tick_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 50;
`ifdef TICK_METER_DEGLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             sq_in;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             lost;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int exp_p[$];
    int exp_h[$];

    clock_tick_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .sq_in     (sq_in),
        .tick      (tick),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic expect_meas(input int p, input int h);
        exp_p.push_back(p);
        exp_h.push_back(h);
    endtask

    task automatic pulse(input int hi, input int lo);
        sq_in = 1'b1;
        repeat (hi) @(negedge clk);
        sq_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Monitor: every meas_valid pops one expected measurement
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tick === 1'b1) tick_cnt++;
            if (meas_valid === 1'b1) begin
                if (exp_p.size() == 0) begin
                    chk("unexpected_meas_valid", 32'd1, 32'd0);
                end else begin
                    chk("meas_period", 32'(period), 32'(exp_p.pop_front()));
                    chk("meas_high_time", 32'(high_time), 32'(exp_h.pop_front()));
                    chk("meas_locked", 32'(locked), 32'd1);
                end
            end
        end
    end

    initial begin
        logic samp [1:5];
        int   t0;
        rst_n = 1'b0;
        sq_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high_time", 32'(high_time), 32'd0);
        chk("rst_meas_valid", 32'(meas_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // First rise: latency and width of tick, no measurement yet
        sq_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            samp[i] = tick;
        end
        sq_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 1; i <= 5; i++) chk($sformatf("tick_latency_%0d", i), 32'(samp[i]), (i == LAT) ? 32'd1 : 32'd0);
        chk("armed_not_locked", 32'(locked), 32'd0);

        // Clean 5/5 clock
        expect_meas(10, 5); pulse(5, 5);
        chk("locked_after_second", 32'(locked), 32'd1);
        expect_meas(10, 5); pulse(5, 5);
        expect_meas(10, 5); pulse(5, 5);

        // Loss of slow clock
        expect_meas(10, 5); pulse(5, 35);
        chk("pre_loss_lost", 32'(lost), 32'd0);
        chk("pre_loss_locked", 32'(locked), 32'd1);
        repeat (25) @(negedge clk);
        chk("loss_lost", 32'(lost), 32'd1);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_period_kept", 32'(period), 32'd10);
        chk("loss_high_kept", 32'(high_time), 32'd5);

        // Recovery edge: lost clears, ARMED, no measurement
        pulse(5, 5);
        chk("recover_lost", 32'(lost), 32'd0);
        chk("recover_locked", 32'(locked), 32'd0);

        // Tick exactly on the timeout cycle
        expect_meas(10, 5); pulse(5, 45);
        expect_meas(50, 5); pulse(5, 5);
        chk("coincide_lost", 32'(lost), 32'd0);
        chk("coincide_locked", 32'(locked), 32'd1);
        chk("coincide_period", 32'(period), 32'd50);

        // Reset mid-measurement while LOCKED
        expect_meas(10, 5);
        pulse(5, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_high_time", 32'(high_time), 32'd0);
        chk("midrst_meas_valid", 32'(meas_valid), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_lost", 32'(lost), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse(5, 5);
        chk("relock_first_edge", 32'(locked), 32'd0);
        expect_meas(10, 5); pulse(5, 5);
        chk("relock_second_edge", 32'(locked), 32'd1);

`ifdef TICK_METER_DEGLITCH_EN
        // One-cycle glitch in the low phase must not produce a tick
        expect_meas(10, 5);
        t0 = tick_cnt;
        pulse(5, 2);
        pulse(1, 2);
        chk("glitch_tick_count", 32'(tick_cnt - t0), 32'd1);
        expect_meas(10, 5); pulse(5, 5);
        chk("glitch_period", 32'(period), 32'd10);
`else
        t0 = tick_cnt;
        expect_meas(10, 5); pulse(5, 5);
        chk("window_tick_count", 32'(tick_cnt - t0), 32'd1);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_p.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
